// File: rtl/alu_modmul_sequencer.sv
// Sequencer computing (a*b) mod n on the shared ALU by MSB-first shift-add-reduce.
// Every ALU operand is registered one edge ahead, so the ALU sees it in the state that uses it.
module alu_modmul_sequencer #(
  parameter int         W       = 32,
  parameter logic [3:0] ALU_ADD = 4'b0000,
  parameter logic [3:0] ALU_SUB = 4'b0001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic         alu_own,
  output logic [3:0]   alu_ctrl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_res,
  input  logic         alu_c
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, DBL, RED1, ADD, RED2, DONE} state_t;

  state_t         state_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   n_r;
  logic [W-1:0]   r_r;
  logic [IW-1:0]  i_r;
  logic [W-1:0]   r_nxt_s;
  logic           op_err_s;

  // Operand validity: n must be nonzero with its top bit clear, and both factors below n.
  always_comb begin
    op_err_s = 1'b0;
    if ((n == {W{1'b0}}) || n[W-1] || (a >= n) || (b >= n)) begin
      op_err_s = 1'b1;
    end else begin
      op_err_s = 1'b0;
    end
  end

  // Next accumulator: plain ALU result after DBL/ADD, conditional on no-borrow after a reduce.
  always_comb begin
    r_nxt_s = r_r;
    case (state_r)
      DBL, ADD: r_nxt_s = alu_res;
      RED1, RED2: begin
        if (alu_c) begin
          r_nxt_s = alu_res;
        end else begin
          r_nxt_s = r_r;
        end
      end
      default: r_nxt_s = r_r;
    endcase
  end

  // Control FSM with registered outputs prepared for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= {W{1'b0}};
      alu_own  <= 1'b0;
      alu_ctrl <= ALU_ADD;
      alu_a    <= {W{1'b0}};
      alu_b    <= {W{1'b0}};
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      n_r      <= {W{1'b0}};
      r_r      <= {W{1'b0}};
      i_r      <= {IW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            n_r  <= n;
            r_r  <= {W{1'b0}};
            i_r  <= IW'(W - 1);
            busy <= 1'b1;
            if (op_err_s) begin
              err     <= 1'b1;
              result  <= {W{1'b0}};
              done    <= 1'b1;
              alu_own <= 1'b0;
              state_r <= DONE;
            end else begin
              err      <= 1'b0;
              alu_own  <= 1'b1;
              alu_ctrl <= ALU_ADD;
              alu_a    <= {W{1'b0}};
              alu_b    <= {W{1'b0}};
              state_r  <= DBL;
            end
          end
        end
        DBL: begin
          r_r      <= r_nxt_s;
          alu_ctrl <= ALU_SUB;
          alu_a    <= r_nxt_s;
          alu_b    <= n_r;
          state_r  <= RED1;
        end
        RED1: begin
          r_r      <= r_nxt_s;
          alu_ctrl <= ALU_ADD;
          alu_a    <= r_nxt_s;
          alu_b    <= b_r[i_r] ? a_r : {W{1'b0}};
          state_r  <= ADD;
        end
        ADD: begin
          r_r      <= r_nxt_s;
          alu_ctrl <= ALU_SUB;
          alu_a    <= r_nxt_s;
          alu_b    <= n_r;
          state_r  <= RED2;
        end
        RED2: begin
          r_r <= r_nxt_s;
          if (i_r == {IW{1'b0}}) begin
            result   <= r_nxt_s;
            done     <= 1'b1;
            alu_own  <= 1'b0;
            alu_ctrl <= ALU_ADD;
            alu_a    <= {W{1'b0}};
            alu_b    <= {W{1'b0}};
            state_r  <= DONE;
          end else begin
            i_r      <= i_r - IW'(1);
            alu_ctrl <= ALU_ADD;
            alu_a    <= r_nxt_s;
            alu_b    <= r_nxt_s;
            state_r  <= DBL;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy     <= 1'b0;
          done     <= 1'b0;
          alu_own  <= 1'b0;
          alu_ctrl <= ALU_ADD;
          alu_a    <= {W{1'b0}};
          alu_b    <= {W{1'b0}};
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
